// File: rtl/a418_pkg.sv
// Shared types and default sizing for the a418 free-pointer manager.
package a418_pkg;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } a418_state_e;

  localparam int unsigned A418_NUMADDR  = 8192;
  localparam int unsigned A418_BITADDR  = 13;
  localparam int unsigned A418_FL_DELAY = 1;
  localparam int unsigned A418_PFDEPTH  = 4;
  localparam int unsigned A418_BITPFD   = 2;

  // Pointer and count types at the default depth.
  typedef logic [A418_BITADDR-1:0] a418_ptr_t;
  typedef logic [A418_BITADDR:0]   a418_cnt_t;

endpackage

// File: rtl/a418_pf_fifo.sv
// Small register FIFO holding prefetched free pointers; head is combinational
// so the top can offer a pointer in the same cycle it is requested.
module a418_pf_fifo
  import a418_pkg::*;
#(
  parameter int unsigned WIDTH = A418_BITADDR,
  parameter int unsigned DEPTH = A418_PFDEPTH,
  parameter int unsigned BITD  = A418_BITPFD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic [BITD:0]    cnt_o
);

  typedef logic [BITD-1:0] idx_t;
  typedef logic [BITD:0]   cnt_t;

  logic [WIDTH-1:0] mem_q [DEPTH];
  idx_t             rd_q;
  idx_t             wr_q;
  cnt_t             cnt_q;

  // DEPTH need not be a power of two, so indices wrap explicitly.
  function automatic idx_t wrap_inc(input idx_t idx);
    return (idx == idx_t'(DEPTH - 1)) ? idx_t'(0) : idx + idx_t'(1);
  endfunction

  // Storage, indices and occupancy; caller never pushes full or pops empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        mem_q[k] <= '0;
      end
      rd_q  <= idx_t'(0);
      wr_q  <= idx_t'(0);
      cnt_q <= cnt_t'(0);
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wrap_inc(wr_q);
      end
      if (pop_i) begin
        rd_q <= wrap_inc(rd_q);
      end
      cnt_q <= cnt_q + cnt_t'(push_i) - cnt_t'(pop_i);
    end
  end

  assign head_o = mem_q[rd_q];
  assign cnt_o  = cnt_q;

endmodule

// File: rtl/algo_1r1w_a418_free_ptr.sv
// Free-pointer manager for the a418 linked-list queue: circular free list in an
// external 1r1w RAM, fronted by a prefetch FIFO for single-cycle allocation.
module algo_1r1w_a418_free_ptr
  import a418_pkg::*;
#(
  parameter int unsigned NUMADDR  = A418_NUMADDR,
  parameter int unsigned BITADDR  = A418_BITADDR,
  parameter int unsigned FL_DELAY = A418_FL_DELAY,
  parameter int unsigned PFDEPTH  = A418_PFDEPTH,
  parameter int unsigned BITPFD   = A418_BITPFD
) (
  input  logic               clk,
  input  logic               rst,
  output logic               ready,
  input  logic               alloc_req,
  output logic               alloc_vld,
  output logic [BITADDR-1:0] alloc_ptr,
  input  logic               free_req,
  input  logic [BITADDR-1:0] free_ptr,
  output logic [BITADDR:0]   free_cnt,
  output logic               err_unf,
  output logic               err_ovf,
  output logic               fl_writeA,
  output logic [BITADDR-1:0] fl_addrA,
  output logic [BITADDR-1:0] fl_dinA,
  output logic               fl_readB,
  output logic [BITADDR-1:0] fl_addrB,
  input  logic [BITADDR-1:0] fl_doutB
);

  typedef logic [BITADDR-1:0] ptr_t;
  typedef logic [BITADDR:0]   cnt_t;
  typedef logic [BITPFD:0]    pfc_t;
  typedef logic [BITPFD+1:0]  occ_t;

  localparam ptr_t LAST_PTR = ptr_t'(NUMADDR - 1);
  localparam cnt_t FULL_CNT = cnt_t'(NUMADDR);

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == LAST_PTR) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

  a418_state_e         state_q;
  ptr_t                init_cnt_q;
  ptr_t                wr_ptr_q, wr_ptr_d;
  ptr_t                rd_ptr_q, rd_ptr_d;
  cnt_t                mem_cnt_q, mem_cnt_d;
  cnt_t                free_cnt_q, free_cnt_d;
  pfc_t                inflight_q, inflight_d;
  logic [FL_DELAY-1:0] rd_vld_q, rd_vld_d;
  logic                ready_q, err_unf_q, err_ovf_q;

  logic init_done_s, alloc_vld_s, alloc_acc_s, free_acc_s, rd_issue_s, rd_ret_s;
  pfc_t pf_cnt_s;
  occ_t pf_occ_s;
  ptr_t pf_head_s;

  a418_pf_fifo #(
    .WIDTH (BITADDR),
    .DEPTH (PFDEPTH),
    .BITD  (BITPFD)
  ) u_pf_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (rd_ret_s),
    .din_i  (fl_doutB),
    .pop_i  (alloc_acc_s),
    .head_o (pf_head_s),
    .cnt_o  (pf_cnt_s)
  );

  // INIT writes one pointer per cycle; the final write hands over to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= INIT;
      init_cnt_q <= ptr_t'(0);
      ready_q    <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (init_done_s) begin
            state_q    <= RUN;
            init_cnt_q <= ptr_t'(0);
            ready_q    <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + ptr_t'(1);
          end
        end
        RUN: begin
          ready_q <= 1'b1;
        end
        default: begin
          state_q    <= INIT;
          init_cnt_q <= ptr_t'(0);
          ready_q    <= 1'b0;
        end
      endcase
    end
  end

  // Accept decisions and next-state arithmetic for the free list.
  always_comb begin
    init_done_s = (state_q == INIT) && (init_cnt_q == LAST_PTR);
    alloc_vld_s = ready_q && (pf_cnt_s != pfc_t'(0));
    alloc_acc_s = alloc_req && alloc_vld_s;
    free_acc_s  = ready_q && free_req && (free_cnt_q != FULL_CNT);
    // Count this cycle's pop so a read is only issued when its return has a slot.
    pf_occ_s    = occ_t'(pf_cnt_s) + occ_t'(inflight_q) - occ_t'(alloc_acc_s);
    rd_issue_s  = ready_q && (mem_cnt_q != cnt_t'(0)) && (pf_occ_s < occ_t'(PFDEPTH));
    rd_ret_s    = rd_vld_q[FL_DELAY-1];
    rd_vld_d    = FL_DELAY'({rd_vld_q, rd_issue_s});
    inflight_d  = inflight_q + pfc_t'(rd_issue_s) - pfc_t'(rd_ret_s);
    if (init_done_s) begin
      wr_ptr_d   = ptr_t'(0);
      rd_ptr_d   = ptr_t'(0);
      mem_cnt_d  = FULL_CNT;
      free_cnt_d = FULL_CNT;
    end else begin
      wr_ptr_d   = free_acc_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d   = rd_issue_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      mem_cnt_d  = mem_cnt_q + cnt_t'(free_acc_s) - cnt_t'(rd_issue_s);
      free_cnt_d = free_cnt_q + cnt_t'(free_acc_s) - cnt_t'(alloc_acc_s);
    end
  end

  // Free-list pointers, counters, read pipe and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= ptr_t'(0);
      rd_ptr_q   <= ptr_t'(0);
      mem_cnt_q  <= cnt_t'(0);
      free_cnt_q <= cnt_t'(0);
      inflight_q <= pfc_t'(0);
      rd_vld_q   <= '0;
      err_unf_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      free_cnt_q <= free_cnt_d;
      inflight_q <= inflight_d;
      rd_vld_q   <= rd_vld_d;
      err_unf_q  <= ready_q && alloc_req && !alloc_vld_s;
      err_ovf_q  <= ready_q && free_req && (free_cnt_q == FULL_CNT);
    end
  end

  // RAM ports are held idle while reset is asserted.
  always_comb begin
    fl_writeA = !rst && ((state_q == INIT) || free_acc_s);
    fl_addrA  = (state_q == INIT) ? init_cnt_q : wr_ptr_q;
    fl_dinA   = (state_q == INIT) ? init_cnt_q : free_ptr;
    fl_readB  = !rst && rd_issue_s;
    fl_addrB  = rd_ptr_q;
  end

  assign ready     = ready_q;
  assign alloc_vld = alloc_vld_s;
  assign alloc_ptr = pf_head_s;
  assign free_cnt  = free_cnt_q;
  assign err_unf   = err_unf_q;
  assign err_ovf   = err_ovf_q;

endmodule
